// File: rtl/sequential_shifter.sv
// Iterative shifter: one log2 stage per cycle, fixed S-cycle latency after accept.
// Single operand in flight; result held with o_valid until o_ready.
module sequential_shifter #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  input  logic [1:0]           op,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [N-1:0]         out
);
  localparam int S = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [S-1:0]   cnt;
  logic [S-1:0]   amt;
  logic [1:0]     op_q;
  logic [N-1:0]   work;
  logic [N-1:0]   stage_val;
  logic [S-1:0]   step;

  // Stage k moves the working value by 2^k when bit k of the amount is set;
  // during SRA the working MSB always equals the captured sign bit.
  always_comb begin
    step      = S'(1) << cnt;
    stage_val = work;
    if (amt[cnt]) begin
      case (op_q)
        2'b00:   stage_val = work << step;
        2'b01:   stage_val = work >> step;
        2'b10:   stage_val = $signed(work) >>> step;
        default: stage_val = work;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      amt     <= '0;
      op_q    <= '0;
      work    <= '0;
      out     <= '0;
      i_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            work    <= in;
            amt     <= shamt;
            op_q    <= op;
            cnt     <= '0;
            state   <= SHIFT;
            i_ready <= 1'b0;
          end
        end
        SHIFT: begin
          work <= stage_val;
          cnt  <= cnt + S'(1);
          if (cnt == S'(S - 1)) begin
            out     <= stage_val;
            state   <= DONE;
            o_valid <= 1'b1;
          end
        end
        DONE: begin
          if (o_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            i_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          i_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sequential_shifter.sv
// Directed and randomized checks of sequential_shifter against a behavioural shift model.
module tb_sequential_shifter;
  localparam int N = 32;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] din;
  logic [S-1:0] shamt;
  logic [1:0]   op;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] dout;

  int checks   = 0;
  int failures = 0;

  sequential_shifter #(.N(N)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .in(din), .shamt(shamt), .op(op),
    .o_valid(o_valid), .o_ready(o_ready), .out(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [S-1:0] sh,
                                         input logic [1:0] o);
    case (o)
      2'b00:   model = a << sh;
      2'b01:   model = a >> sh;
      2'b10:   model = $signed(a) >>> sh;
      default: model = a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    din     = $urandom;
    shamt   = S'($urandom_range(0, N - 1));
    op      = 2'($urandom_range(0, 3));
    i_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [S-1:0] sh, input logic [1:0] o,
                        input int stall);
    logic [N-1:0] exp;
    int lat;
    exp = model(a, sh, o);
    @(negedge clk);
    check("idle_i_ready", 32'(i_ready), 32'd1);
    i_valid = 1'b1; din = a; shamt = sh; op = o;
    o_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    o_ready = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      scramble();
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(S));
    check("result", dout, exp);
    for (int k = 0; k < stall; k++) begin
      scramble();
      @(posedge clk);
      @(negedge clk);
      check("stall_o_valid", 32'(o_valid), 32'd1);
      check("stall_out", dout, exp);
      check("stall_i_ready", 32'(i_ready), 32'd0);
    end
    scramble();
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    o_ready = 1'b0;
    check("post_hs_i_ready", 32'(i_ready), 32'd1);
    check("post_hs_o_valid", 32'(o_valid), 32'd0);
    check("post_hs_out_kept", dout, exp);
  endtask

  initial begin
    logic [N-1:0] v;
    logic seen;
    rst = 1'b1; i_valid = 1'b0; din = '0; shamt = '0; op = '0; o_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_out", dout, 32'h0);
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_i_ready", 32'(i_ready), 32'd1);

    // Boundary and directed cases
    run_op(32'h8000_0000, 5'd31, 2'b10, 0);
    run_op(32'hFFFF_FFFF, 5'd4, 2'b01, 0);
    run_op(32'hFFFF_FFFF, 5'd4, 2'b10, 1);
    run_op(32'hFFFF_FFFF, 5'd4, 2'b00, 0);
    for (int k = 0; k < 4; k++) run_op(32'h1234_5678, 5'd0, 2'(k), 0);
    run_op(32'h1234_5678, 5'd7, 2'b11, 0);
    run_op(32'h0000_0001, 5'd31, 2'b00, 3);

    // Reset after the second SHIFT edge aborts the operand
    @(negedge clk);
    i_valid = 1'b1; din = 32'hDEAD_BEEF; shamt = 5'd3; op = 2'b00;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    o_ready = 1'b1;
    check("abort_out", dout, 32'h0);
    check("abort_o_valid", 32'(o_valid), 32'd0);
    check("abort_i_ready", 32'(i_ready), 32'd1);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    o_ready = 1'b0;

    // Reset wins over an input handshake at the same edge
    @(negedge clk);
    i_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    check("rst_prio_i_ready", 32'(i_ready), 32'd1);
    check("rst_prio_o_valid", 32'(o_valid), 32'd0);

    // Random operands: first half positive, second half negative
    for (int i = 0; i < 200; i++) begin
      if (failures >= 25) break;
      v = $urandom;
      v[N-1] = (i >= 100);
      run_op(v, S'($urandom_range(0, N - 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
